fp_mult_arbiter: RTL and testbench

- Shares one external pipelined FP32 multiplier between N_REQ requesters.
- Round-robin issue, at most one operation per cycle. Each operation's requester index is tracked through a fixed-latency tag pipe, and the result plus flags are steered back to that requester.
- Generates the multiplier's synchronous reset.
- Limits per-requester outstanding operations.

---
 rtl/fp_mult_pkg.sv | 27 ++
 rtl/fp_rr_arbiter.sv | 41 ++++
 rtl/fp_mult_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
//
// Contents:
//   FP_W, FLAG_W   - operand/result width and flag vector width
//   EXC/OVF/UNF    - bit positions inside the {exception, overflow, underflow} flags
//   MAX_REQ/IDX_W  - largest supported requester count and the index width that covers it
//   tag_t          - one slot of the tag pipe: which requester owns the operation in flight
package fp_mult_pkg;

    localparam int FP_W   = 32;
    localparam int FLAG_W = 3;

    localparam int EXC = 2;
    localparam int OVF = 1;
    localparam int UNF = 0;

    // The index width is fixed for the largest requester count so tag_t has one shape
    // for every instance of the arbiter.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin picker.
//
// Picks the first eligible requester, starting the search at ptr+1 and wrapping, so the
// most recent winner (ptr) has the lowest priority on the next decision.
//
// Ports:
//   eligible [N]     - requesters that may be granted this cycle
//   ptr      [IDX_W] - index of the last winner
//   grant    [N]     - one-hot winner, all zeros when nothing is eligible
//   idx      [IDX_W] - encoded winner (0 when nothing is eligible)
//   any              - a winner exists
module fp_rr_arbiter
    import fp_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one external pipelined FP32 multiplier between N_REQ requesters.
//
// One operation is issued per cycle at most, chosen round-robin. The owner of every issued
// operation rides a tag pipe whose depth matches the multiplier latency, so when the
// product appears the tag at the end of the pipe says whose it is. The block also drives
// the multiplier's synchronous reset and caps the operations each requester has in flight.
//
// Ports:
//   clk                - clock
//   reset              - asynchronous, active-low reset
//   req_valid  [N_REQ] - per-requester request valid
//   req_ready  [N_REQ] - one-hot grant (combinational); a handshake is valid & ready at the edge
//   req_a/req_b        - packed operands, requester i in bits [32i+31:32i]
//   rsp_valid  [N_REQ] - one-cycle response pulse for the owning requester
//   rsp_result [32]    - product, passed straight through from the multiplier
//   rsp_flags  [3]     - {exception, overflow, underflow}, passed straight through
//   mul_a/mul_b [32]   - registered operands to the multiplier
//   mul_rst            - active-high synchronous reset to the multiplier
//   mul_result/mul_flags - multiplier outputs, MULT_LAT edges after an operand change
//   busy               - any operation still in flight
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MULT_LAT  = 2,
    parameter int MAX_OUTST = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [FP_W*N_REQ-1:0]   req_a,
    input  logic [FP_W*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [FP_W-1:0]         rsp_result,
    output logic [FLAG_W-1:0]       rsp_flags,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    output logic                    mul_rst,
    input  logic [FP_W-1:0]         mul_result,
    input  logic [FLAG_W-1:0]       mul_flags,
    output logic                    busy
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int RST_W = $clog2(MULT_LAT + 2);
    // A tag issued at edge t must be at the pipe output in the cycle after edge t+MULT_LAT,
    // which takes one slot per edge including the issuing one.
    localparam int TAG_DEPTH = MULT_LAT + 1;

    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] outst [N_REQ];
    logic [IDX_W-1:0] ptr;
    tag_t             tag_p [TAG_DEPTH];
    tag_t             rsp_tag;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [FP_W-1:0]  sel_a;
    logic [FP_W-1:0]  sel_b;

    // ------------------------------------------------------------------
    // Multiplier reset: held for MULT_LAT+1 edges after reset release so
    // the multiplier pipeline is flushed before the first operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_rst <= 1'b1;
            rst_cnt <= '0;
        end else if (mul_rst) begin
            if (rst_cnt == RST_W'(MULT_LAT)) begin
                mul_rst <= 1'b0;
            end else begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST)) && !mul_rst;
        end
    end

    fp_rr_arbiter #(
        .N        (N_REQ)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (win_idx),
        .any      (win_any)
    );

    // Eligibility already includes req_valid, so a grant is always a handshake.
    assign req_ready = grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[FP_W*i +: FP_W];
                sel_b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue: operand registers and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a <= '0;
            mul_b <= '0;
            ptr   <= IDX_W'(N_REQ - 1);
        end else if (win_any) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            ptr   <= win_idx;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: one slot per edge, bubbles enter as valid = 0
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0].valid <= win_any;
            tag_p[0].idx   <= win_idx;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign rsp_tag = tag_p[TAG_DEPTH-1];

    // ------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rsp_tag.valid && (rsp_tag.idx == IDX_W'(i));
        end
    end

    assign rsp_result = mul_result;
    assign rsp_flags  = mul_flags;

    // ------------------------------------------------------------------
    // Outstanding counters: a grant and a response for the same requester
    // in one cycle cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !rsp_valid[i]) begin
                    outst[i] <= outst[i] + CNT_W'(1);
                end else if (rsp_valid[i] && !grant[i]) begin
                    outst[i] <= outst[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            busy = busy | tag_p[i].valid;
        end
        for (int i = 0; i < N_REQ; i++) begin
            busy = busy | (outst[i] != '0);
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
module tb_fp_mult_arbiter;

    localparam int N    = 4;
    localparam int L    = 4;
    localparam int MAXO = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_result;
    logic [2:0]      rsp_flags;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic            mul_rst;
    logic [31:0]     mul_result;
    logic [2:0]      mul_flags;
    logic            busy;

    always #5 clk = ~clk;

    fp_mult_arbiter #(
        .N_REQ     (N),
        .MULT_LAT  (L),
        .MAX_OUTST (MAXO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rst    (mul_rst),
        .mul_result (mul_result),
        .mul_flags  (mul_flags),
        .busy       (busy)
    );

    // Simplified FP32 multiply (denormals as zero, truncation), returns {flags, result}.
    function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'h7FC00000};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, s, 31'd0};
        return {3'b000, s, e[7:0], m};
    endfunction

    // External multiplier: output changes L edges after its operands change.
    logic [34:0] mpipe [L];
    always @(posedge clk) begin
        if (mul_rst) begin
            for (int i = 0; i < L; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= fp_mul(mul_a, mul_b);
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign {mul_flags, mul_result} = mpipe[L-1];

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } op_t;

    op_t         q[$];
    int          m_outst [N];
    int          m_ptr;
    bit          m_mrst;
    int          m_rcnt;
    logic [31:0] m_a, m_b;
    int          cyc;
    int          total;
    int          bad;

    logic [N-1:0] obs_ready, obs_rsp, hs;
    logic [31:0]  obs_res;
    logic [2:0]   obs_flags;
    logic         obs_busy, obs_mrst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model for the
    // coming rising edge, then return 1 time unit after that edge.
    task automatic step();
        logic [N-1:0] e_ready, e_rsp;
        logic [34:0]  fr;
        int           win, j;
        bit           has_rsp, any_m;
        @(negedge clk);
        if (!reset) begin
            q.delete();
            for (int i = 0; i < N; i++) m_outst[i] = 0;
            m_ptr  = N - 1;
            m_mrst = 1'b1;
            m_rcnt = 0;
            m_a    = '0;
            m_b    = '0;
        end
        e_ready = '0;
        win     = -1;
        if (!m_mrst) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (win < 0 && req_valid[j] && m_outst[j] < MAXO) begin
                    win        = j;
                    e_ready[j] = 1'b1;
                end
            end
        end
        e_rsp   = '0;
        has_rsp = (q.size() > 0) && (q[0].due == cyc);
        if (has_rsp) e_rsp[q[0].idx] = 1'b1;
        any_m = (q.size() != 0);

        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("mul_rst", mul_rst, m_mrst);
        chk("busy", busy, any_m);
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        if (has_rsp) begin
            fr = fp_mul(q[0].a, q[0].b);
            chk("rsp_result", rsp_result, fr[31:0]);
            chk("rsp_flags", rsp_flags, fr[34:32]);
        end

        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_res   = rsp_result;
        obs_flags = rsp_flags;
        obs_busy  = busy;
        obs_mrst  = mul_rst;
        hs        = req_ready & req_valid;

        if (reset) begin
            if (has_rsp) begin
                m_outst[q[0].idx]--;
                void'(q.pop_front());
            end
            if (win >= 0) begin
                q.push_back('{idx: win, a: req_a[32*win +: 32], b: req_b[32*win +: 32], due: cyc + 1 + L});
                m_outst[win]++;
                m_ptr = win;
                m_a   = req_a[32*win +: 32];
                m_b   = req_b[32*win +: 32];
            end
            if (m_mrst) begin
                m_rcnt++;
                if (m_rcnt == L + 1) m_mrst = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b, output int hs_cyc);
        bit got;
        got    = 1'b0;
        hs_cyc = -1;
        set_op(i, a, b);
        req_valid[i] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            if (hs[i]) begin
                got    = 1'b1;
                hs_cyc = cyc - 1;
            end
        end
        req_valid[i] = 1'b0;
        chk("issue_handshake", got, 1);
    endtask

    task automatic wait_rsp(input int i, output int rsp_cyc);
        rsp_cyc = -1;
        for (int k = 0; k < 30 && rsp_cyc < 0; k++) begin
            step();
            if (obs_rsp[i]) rsp_cyc = cyc - 1;
        end
        chk("rsp_seen", (rsp_cyc >= 0), 1);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int         sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(200, 254));
            4:       e = 8'($urandom_range(1, 40));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    initial begin
        int          cnt, hsc, rsc, dens;
        int          gseq[$];
        int          rseq[$];
        logic [11:0] pat;
        logic [34:0] fr;

        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;

        fr = fp_mul(32'h40000000, 32'h40400000);
        chk("model_2x3", fr, {3'b000, 32'h40C00000});
        fr = fp_mul(32'h3FC00000, 32'h3FC00000);
        chk("model_1p5sq", fr, {3'b000, 32'h40100000});
        fr = fp_mul(32'h7F000000, 32'h7F000000);
        chk("model_ovf", fr, {3'b010, 32'h7F800000});

        // reset state, then release with requester 0 waiting
        repeat (3) step();
        chk("reset_mul_rst", obs_mrst, 1);
        chk("reset_busy", obs_busy, 0);
        chk("reset_ready", obs_ready, 0);
        set_op(0, 32'h3F800000, 32'h40000000);
        req_valid[0] = 1'b1;
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs_ready[0]) break;
            cnt++;
        end
        chk("rst_hold_cycles", cnt, L + 1);
        req_valid[0] = 1'b0;
        drain();

        // 2.0 x 3.0 from requester 1
        issue_one(1, 32'h40000000, 32'h40400000, hsc);
        wait_rsp(1, rsc);
        chk("rsp_edge_offset", rsc - hsc, L + 1);
        chk("res_2x3", obs_res, 32'h40C00000);
        chk("flags_2x3", obs_flags, 3'b000);
        drain();

        // move the pointer to 3 so the next sweep starts at 0
        issue_one(3, 32'h3F800000, 32'h3F800000, hsc);
        drain();

        // all requesters continuously valid with 1.5 x 1.5
        for (int i = 0; i < N; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (oh_idx(hs) >= 0) gseq.push_back(oh_idx(hs));
            if (obs_rsp != 0) begin
                rseq.push_back(oh_idx(obs_rsp));
                chk("sq_result", obs_res, 32'h40100000);
            end
        end
        req_valid = '0;
        for (int k = 0; k < 30 && q.size() != 0; k++) begin
            step();
            if (obs_rsp != 0) begin
                rseq.push_back(oh_idx(obs_rsp));
                chk("sq_result", obs_res, 32'h40100000);
            end
        end
        chk("grant_count", gseq.size(), 16);
        for (int k = 0; k < 8; k++) chk("grant_order", gseq[k], k % 4);
        chk("rsp_count", rseq.size(), gseq.size());
        for (int k = 0; k < rseq.size() && k < gseq.size(); k++) chk("rsp_order", rseq[k], gseq[k]);
        drain();

        // requester 2 alone hits the outstanding limit
        set_op(2, 32'h3F800000, 32'h40000000);
        req_valid[2] = 1'b1;
        pat = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            pat[k] = obs_ready[2];
        end
        chk("req2_ready_pattern", pat, 12'h1C7);
        req_valid = '0;
        drain();

        // overflow
        issue_one(0, 32'h7F000000, 32'h7F000000, hsc);
        wait_rsp(0, rsc);
        chk("res_ovf", obs_res, 32'h7F800000);
        chk("flags_ovf", obs_flags, 3'b010);
        drain();

        // reset with two operations in flight
        set_op(0, 32'h40000000, 32'h40000000);
        set_op(1, 32'h40400000, 32'h40400000);
        req_valid = 4'b0011;
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            cnt += (hs != 0) ? 1 : 0;
            req_valid = req_valid & ~hs;
        end
        chk("inflight_issued", cnt, 2);
        req_valid = '0;
        step();
        reset = 1'b0;
        step();
        chk("midrst_mul_rst", obs_mrst, 1);
        chk("midrst_busy", obs_busy, 0);
        step();
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_rsp != 0) cnt++;
        end
        chk("rsp_after_reset", cnt, 0);

        // randomized traffic with one reset pulse
        dens = 60;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) dens = $urandom_range(10, 100);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < dens);
                    set_op(i, rand_fp(), rand_fp());
                end
            end
            if (k == 1500) reset = 1'b0;
            if (k == 1502) reset = 1'b1;
            step();
        end
        req_valid = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
